entropy_reader: RTL
===================

Name: entropy_reader

Overview:
- Bus initiator for the entropy responder's cs/we/addr/dwrite/dread register interface.
- After reset, and on request, writes the ring-oscillator seed pair (rng1 at 0x00, rng2 at 0x01).
- Then polls the p (0x11) and n (0x12) sample registers, whitens each pair by XOR and packs two 16-bit results into a 32-bit word.
- Delivers each word on a valid/ready stream to downstream consumers (e.g. a conditioning or TRNG FIFO block).

Parameters:
- SAMPLE_DELAY, 4, idle cycles in WAIT before each p/n read pair; legal range 1..65535.
- DEFAULT_SEED, 8'h55, seed written as rng1 at reset exit; rng2 is always written as ~seed.

Ports:
- clk  input  1  clock
- nreset  input  1  reset, asynchronous, active-low
- enable  input  1  level; permits sampling
- cfg_seed  input  8  seed for rng1 (rng2 = ~cfg_seed)
- cfg_update  input  1  one-cycle pulse; request seed rewrite using cfg_seed
- m_cs  output  1  responder chip select
- m_we  output  1  responder write enable
- m_addr  output  8  responder register address
- m_dwrite  output  16  responder write data
- m_dread  input  16  responder read data; combinational, valid in the same cycle as cs=1, we=0
- out_data  output  32  packed whitened word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  FSM not in IDLE
- word_count  output  16  words accepted by consumer; wraps 0xFFFF->0x0000

Behaviour:
- Reset values:
  - m_cs=0, m_we=0, m_addr=0x00, m_dwrite=0x0000.
  - out_data=0, out_valid=0, word_count=0, busy=1.
  - State WR1. Seed register = DEFAULT_SEED. Half index = 0. Update-pending = 0.
- All outputs are registered. m_* values are the values for the cycle the FSM is in that state. m_cs=0 in every non-access state. m_dread is captured on the edge that ends an access cycle.
- One bus access per cycle at most. No two consecutive cycles target the same address.
- States:
  - WR1: m_cs=1, m_we=1, m_addr=0x00, m_dwrite={seed,8'h00}. Next: WR2.
  - WR2: m_cs=1, m_we=1, m_addr=0x01, m_dwrite={8'h00,~seed}. Next: IDLE.
  - IDLE: busy=0.
    - cfg_update=1 -> latch cfg_seed, go WR1. This has priority over enable.
    - Else enable=1 -> go WAIT with delay counter=0.
  - WAIT: counter increments each cycle.
    - enable=0 -> go IDLE; discard a partial half (half index reset to 0). A completed word already in out_data is kept.
    - Else, at counter=SAMPLE_DELAY-1 -> go RDP.
  - RDP: m_cs=1, m_we=0, m_addr=0x11. Capture p_reg<=m_dread. Next: RDN.
  - RDN: m_cs=1, m_we=0, m_addr=0x12. Result = p_reg ^ m_dread.
    - Half 0: store result into low half. Half index<=1. Go WAIT.
    - Half 1: form {result, low half}.
      - If out_valid=0, or out_valid=1 and out_ready=1 this cycle: load out_data, out_valid<=1, half<=0, then go to the post-word branch.
      - Else go FULL holding the word.
  - FULL: no bus access. When out_valid=0 or out_ready=1: load the held word, out_valid<=1, then take the post-word branch.
  - Post-word branch: update-pending -> WR1; else enable -> WAIT; else IDLE.
- Access states always complete; enable is not checked in WR1, WR2, RDP, RDN.
- cfg_update outside IDLE sets update-pending and latches cfg_seed (last pulse wins). The rewrite happens at the next post-word branch or the next IDLE entry. update-pending clears on entry to WR1.
- Stream handshake:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid falls the cycle after a handshake unless a new word loads that same cycle.
  - word_count increments on every out_valid & out_ready.
- Latency with enable held high from IDLE, decision edge t0:
  - WAIT occupies cycles 1..D, RDP cycle D+1, RDN cycle D+2.
  - Second half: WAIT D+3..2D+2, RDP 2D+3, RDN 2D+4.
  - out_valid=1 from cycle 2D+5. D=4 gives cycle 13.
- Reset asserted mid-operation: immediate return to reset values, including bus outputs low. The seed reverts to DEFAULT_SEED and is rewritten via WR1/WR2.

Test Plan:
- Reset release, DEFAULT_SEED=0x55 -> cycle 0: cs=1, we=1, addr=0x00, dwrite=0x5500; cycle 1: addr=0x01, dwrite=0x00AA; cycle 2: busy=0, m_cs=0.
- enable=1, D=4, model p=0x1234/0xF0F0 and n=0x00FF/0x0F0F on successive reads, out_ready=1 -> out_valid in cycle 13 with out_data=0xFFFF12CB; word_count=1 after the handshake.
- out_ready=0 for 30 cycles -> first word held stable. The second word completes and FSM sits in FULL with m_cs=0. Raise out_ready -> second word appears the next cycle; no reads occur while in FULL.
- cfg_update with cfg_seed=0x3C during a sample pair -> writes 0x3C00@0x00 and 0x00C3@0x01 only after the current word is loaded, then sampling resumes.
- enable dropped during the second WAIT -> IDLE; the next word after re-enable uses two fresh read pairs, with no stale low half.
- nreset pulsed during RDN -> all outputs reach reset values asynchronously; on release, WR1/WR2 replay with 0x55/0xAA.

Source files
------------

// File: rtl/entropy_reader.sv
// entropy_reader: bus initiator for the entropy responder.
// It writes the ring-oscillator seed pair (rng1 at 0x00, rng2 at 0x01), then
// polls the p (0x11) and n (0x12) sample registers. Each pair is whitened by
// XOR, two 16-bit results are packed into a 32-bit word, and each word is
// delivered on a valid/ready stream.
module entropy_reader #(
  parameter int unsigned SAMPLE_DELAY = 4,
  parameter logic [7:0]  DEFAULT_SEED = 8'h55
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        enable,
  input  logic [7:0]  cfg_seed,
  input  logic        cfg_update,
  output logic        m_cs,
  output logic        m_we,
  output logic [7:0]  m_addr,
  output logic [15:0] m_dwrite,
  input  logic [15:0] m_dread,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    ST_WR1, ST_WR2, ST_IDLE, ST_WAIT, ST_RDP, ST_RDN, ST_FULL
  } state_t;

  localparam logic [7:0]  ADDR_RNG1  = 8'h00;
  localparam logic [7:0]  ADDR_RNG2  = 8'h01;
  localparam logic [7:0]  ADDR_P     = 8'h11;
  localparam logic [7:0]  ADDR_N     = 8'h12;
  localparam logic [15:0] DELAY_LAST = 16'(SAMPLE_DELAY - 1);

  state_t      state_q, state_d, post_state;
  logic [7:0]  seed_q, seed_d;
  logic        pending_q, pending_d;
  logic        half_q, half_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] p_q, p_d;
  logic [15:0] low_q, low_d;
  logic [31:0] held_q, held_d;
  logic        m_cs_q, m_cs_d;
  logic        m_we_q, m_we_d;
  logic [7:0]  m_addr_q, m_addr_d;
  logic [15:0] m_dwrite_q, m_dwrite_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [15:0] word_count_q, word_count_d;
  logic [15:0] result;
  logic        can_load;

  // Next-state, datapath and registered-output decode for the whole FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    seed_d       = seed_q;
    pending_d    = pending_q;
    half_d       = half_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    low_d        = low_q;
    held_d       = held_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~out_ready;
    word_count_d = word_count_q;
    result       = p_q ^ m_dread;
    can_load     = ~out_valid_q | out_ready;

    if (out_valid_q && out_ready) word_count_d = word_count_q + 16'd1;

    // Any seed request is latched at once; outside IDLE it is deferred.
    if (cfg_update) begin
      seed_d = cfg_seed;
      if (state_q != ST_IDLE) pending_d = 1'b1;
    end

    // Where to go after a word has been loaded into out_data.
    if (pending_d)   post_state = ST_WR1;
    else if (enable) post_state = ST_WAIT;
    else             post_state = ST_IDLE;

    case (state_q)
      // Right after reset the bus is still idle, so WR1 is driven first.
      ST_WR1:  if (m_cs_q) state_d = ST_WR2;
      ST_WR2:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (cfg_update || pending_q) state_d = ST_WR1;
        else if (enable)             state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          half_d  = 1'b0;
        end else if (cnt_q == DELAY_LAST) begin
          state_d = ST_RDP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RDP: begin
        p_d     = m_dread;
        state_d = ST_RDN;
      end
      ST_RDN: begin
        if (!half_q) begin
          low_d   = result;
          half_d  = 1'b1;
          state_d = ST_WAIT;
        end else begin
          half_d = 1'b0;
          if (can_load) begin
            out_data_d  = {result, low_q};
            out_valid_d = 1'b1;
            state_d     = post_state;
          end else begin
            held_d  = {result, low_q};
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (can_load) begin
          out_data_d  = held_q;
          out_valid_d = 1'b1;
          state_d     = post_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_WR1) pending_d = 1'b0;
    if (state_d == ST_WAIT && state_q != ST_WAIT) cnt_d = '0;

    // Bus outputs describe the access of the state being entered.
    m_cs_d     = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = 8'h00;
    m_dwrite_d = 16'h0000;
    case (state_d)
      ST_WR1: begin
        m_cs_d = 1'b1; m_we_d = 1'b1; m_addr_d = ADDR_RNG1;
        m_dwrite_d = {seed_d, 8'h00};
      end
      ST_WR2: begin
        m_cs_d = 1'b1; m_we_d = 1'b1; m_addr_d = ADDR_RNG2;
        m_dwrite_d = {8'h00, ~seed_d};
      end
      ST_RDP:  begin m_cs_d = 1'b1; m_addr_d = ADDR_P; end
      ST_RDN:  begin m_cs_d = 1'b1; m_addr_d = ADDR_N; end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_WR1;
      seed_q       <= DEFAULT_SEED;
      pending_q    <= 1'b0;
      half_q       <= 1'b0;
      cnt_q        <= '0;
      p_q          <= '0;
      low_q        <= '0;
      held_q       <= '0;
      m_cs_q       <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_dwrite_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
      word_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      seed_q       <= seed_d;
      pending_q    <= pending_d;
      half_q       <= half_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      low_q        <= low_d;
      held_q       <= held_d;
      m_cs_q       <= m_cs_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_dwrite_q   <= m_dwrite_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
    end
  end

  assign m_cs       = m_cs_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_dwrite   = m_dwrite_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule
